mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage, downstream of the decode controller; consumes its MDUOp and MDU_start fields together with the forwarded rs/rt operands.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy flag.
- The hazard unit stalls D whenever an MDU-related instruction is in D while busy or start is high.
- The E-stage AO mux reads HI and LO directly for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch a mult/multu/div/divu this cycle (E-stage MDU_start).
- mdu_op  input  3  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  high while a multi-cycle operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: one clk edge with reset=1 clears HI, LO, busy, the counter, the temp result and the pending op. Reset during an operation discards the result.
- Launch:
  - Requires start=1, busy=0 and mdu_op in 1..4.
  - At that edge the unit computes the 64-bit result into internal tmp_hi/tmp_lo, loads the counter with MULT_CYCLES or DIV_CYCLES, and sets busy=1.
  - start with mdu_op not in 1..4 is ignored.
- Timing:
  - If launch is at edge t0, busy=1 for exactly N cycles after t0.
  - At the N-th edge after t0, HI/LO take tmp_hi/tmp_lo, busy drops to 0 and the counter reaches 0.
  - HI/LO keep their old values while busy=1; no partial update is visible.
- Counter: decrements once per edge while busy; no wrap. It is 4 bits wide.
- MULT: {HI,LO} = signed(A) * signed(B), full 64 bits.
- MULTU: {HI,LO} = A * B, unsigned 64 bits.
- DIV:
  - LO = signed quotient, truncated toward zero; HI = remainder, carrying the sign of A.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = A / B, HI = A % B, both unsigned.
- Divide by zero: the busy sequence still runs DIV_CYCLES, and HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - Take effect when mdu_op is 5 or 6 with busy=0, independent of start.
  - HI (or LO) <= A at that edge, with no busy cycles.
- Protocol guard:
  - start, MTHI or MTLO arriving while busy=1 is ignored; the in-flight op is unaffected.
  - The hazard unit guarantees this never happens; the guard exists only for robustness.
- Simultaneous events:
  - The completion edge and a new launch on the same cycle cannot coincide, because busy=1 blocks launch.
  - On the cycle after busy falls, a launch or MTHI/MTLO is accepted normally.
- Outputs are registers only; there is no combinational path from the inputs to busy, HI or LO.
- busy is not asserted in the start cycle itself; external stall logic ORs start with busy.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3 → busy=1 for 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged while busy.
- multu, A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (-7), B=2 → busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu, A=7, B=0, with HI/LO preloaded to 0x11/0x22 → 10 busy cycles, HI=0x11, LO=0x22.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on the next cycle → HI/LO updated on consecutive edges; busy stays 0 throughout.
- Launch mult, then pulse start with div and MTHI on cycles 2 and 3 of busy → both ignored; final HI/LO equal the mult result; busy length stays 5.
- Launch div, assert reset on busy cycle 4 → at the next edge busy=0, HI=0, LO=0; no later update; a new mult launched after reset completes correctly.

Source files
------------

// File: rtl/mdu_unit_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
// The E stage drives the operation; the unit returns busy and HI/LO.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, mdu_op, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, mdu_op, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at launch and committed only when the busy count expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave mdu
);
    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;
    logic        wr_q, wr_d;

    logic        is_mul, is_div, is_sdiv, launch;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, dvd, dvs;
    logic [31:0] uq, ur, q, r;
    logic [63:0] res;

    assign is_mul  = (mdu.mdu_op == 3'd1) || (mdu.mdu_op == 3'd2);
    assign is_div  = (mdu.mdu_op == 3'd3) || (mdu.mdu_op == 3'd4);
    assign is_sdiv = (mdu.mdu_op == 3'd3);
    assign launch  = (state_q == S_IDLE) && mdu.start && (is_mul || is_div);

    assign prod_s = $signed({{32{mdu.A[31]}}, mdu.A})
                  * $signed({{32{mdu.B[31]}}, mdu.B});
    assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

    // Signed divide via magnitudes; -2^31 / -1 wraps to 0x80000000 naturally.
    assign a_mag = mdu.A[31] ? (32'd0 - mdu.A) : mdu.A;
    assign b_mag = mdu.B[31] ? (32'd0 - mdu.B) : mdu.B;
    assign dvd   = is_sdiv ? a_mag : mdu.A;
    assign dvs   = is_sdiv ? b_mag : mdu.B;
    assign uq    = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    assign ur    = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    assign q     = (is_sdiv && (mdu.A[31] ^ mdu.B[31])) ? (32'd0 - uq) : uq;
    assign r     = (is_sdiv && mdu.A[31]) ? (32'd0 - ur) : ur;

    always_comb begin
        res = 64'd0;
        unique case (1'b1)
            mdu.mdu_op == 3'd1: res = prod_s;
            mdu.mdu_op == 3'd2: res = prod_u;
            is_div:             res = {r, q};
            default:            res = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        wr_d     = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d  = S_BUSY;
                    cnt_d    = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    tmp_hi_d = res[63:32];
                    tmp_lo_d = res[31:0];
                    wr_d     = !(is_div && (mdu.B == 32'd0));
                end else if (mdu.mdu_op == 3'd5) begin
                    hi_d = mdu.A;
                end else if (mdu.mdu_op == 3'd6) begin
                    lo_d = mdu.A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    wr_d    = 1'b0;
                    if (wr_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mdu.busy = (state_q == S_BUSY);
        mdu.HI   = hi_q;
        mdu.LO   = lo_q;
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: reference model of HI/LO/busy checked every cycle,
// plus directed literal checks and randomized traffic.
module tb_mdu_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    mdu_unit_if mif ();

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: remaining busy cycles plus a pending 64-bit result.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] p_hi = '0, p_lo = '0;
    bit          p_wr = 1'b0;

    always @(posedge clk) begin
        longint          s, rm;
        longint unsigned u;
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0;
            p_hi = '0; p_lo = '0; p_wr = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (mif.start && mif.mdu_op >= 3'd1 && mif.mdu_op <= 3'd4) begin
            p_wr = 1'b1;
            case (mif.mdu_op)
                3'd1: begin
                    s = longint'($signed(mif.A)) * longint'($signed(mif.B));
                    {p_hi, p_lo} = s;
                    m_left = MC;
                end
                3'd2: begin
                    u = longint'({32'd0, mif.A}) * longint'({32'd0, mif.B});
                    {p_hi, p_lo} = u;
                    m_left = MC;
                end
                3'd3: begin
                    m_left = DC;
                    if (mif.B == 0) p_wr = 1'b0;
                    else begin
                        s  = longint'($signed(mif.A)) / longint'($signed(mif.B));
                        rm = longint'($signed(mif.A)) % longint'($signed(mif.B));
                        p_lo = s[31:0];
                        p_hi = rm[31:0];
                    end
                end
                default: begin
                    m_left = DC;
                    if (mif.B == 0) p_wr = 1'b0;
                    else begin
                        p_lo = mif.A / mif.B;
                        p_hi = mif.A % mif.B;
                    end
                end
            endcase
        end else if (mif.mdu_op == 3'd5) begin
            m_hi = mif.A;
        end else if (mif.mdu_op == 3'd6) begin
            m_lo = mif.A;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            tests++;
            if (mif.busy !== (m_left > 0)) begin
                fails++;
                $display("FAIL cyc_busy t=%0t got %b want %b", $time, mif.busy, m_left > 0);
            end
            tests++;
            if (mif.HI !== m_hi) begin
                fails++;
                $display("FAIL cyc_hi t=%0t got %h want %h", $time, mif.HI, m_hi);
            end
            tests++;
            if (mif.LO !== m_lo) begin
                fails++;
                $display("FAIL cyc_lo t=%0t got %h want %h", $time, mif.LO, m_lo);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
        check({name, "_hi"}, mif.HI, hi);
        check({name, "_lo"}, mif.LO, lo);
        check({name, "_mhi"}, m_hi, hi);
        check({name, "_mlo"}, m_lo, lo);
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        @(negedge clk);
        mif.start = 1'b1; mif.mdu_op = op; mif.A = a; mif.B = b;
        @(negedge clk);
        mif.start = 1'b0; mif.mdu_op = 3'd0;
        n = 0;
        while (mif.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                                32'h80000000, 32'h7FFFFFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int n;
        mif.start = 1'b0; mif.mdu_op = 3'd0; mif.A = '0; mif.B = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        check("rst_busy", {31'd0, mif.busy}, 32'd0);
        check_hl("rst", 32'h0, 32'h0);

        launch(3'd1, 32'hFFFFFFFE, 32'd3, n);
        check("mult_len", n, 5);
        check_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        launch(3'd2, 32'hFFFFFFFF, 32'd2, n);
        check("multu_len", n, 5);
        check_hl("multu", 32'h00000001, 32'hFFFFFFFE);

        launch(3'd3, 32'hFFFFFFF9, 32'd2, n);
        check("div_len", n, 10);
        check_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        @(negedge clk); mif.mdu_op = 3'd5; mif.A = 32'h11;
        @(negedge clk); mif.mdu_op = 3'd6; mif.A = 32'h22;
        @(negedge clk); mif.mdu_op = 3'd0;
        check_hl("preload", 32'h11, 32'h22);
        launch(3'd4, 32'd7, 32'd0, n);
        check("div0_len", n, 10);
        check_hl("div0", 32'h11, 32'h22);

        @(negedge clk); mif.mdu_op = 3'd5; mif.A = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", mif.HI, 32'h12345678);
        mif.mdu_op = 3'd6; mif.A = 32'h9ABCDEF0;
        @(negedge clk); mif.mdu_op = 3'd0;
        check_hl("mtlo", 32'h12345678, 32'h9ABCDEF0);

        launch(3'd3, 32'h80000000, 32'hFFFFFFFF, n);
        check_hl("ovf", 32'h0, 32'h80000000);

        // Intrusions during busy must be ignored.
        @(negedge clk); mif.start = 1'b1; mif.mdu_op = 3'd1; mif.A = 5; mif.B = 7;
        @(negedge clk); mif.start = 1'b0; mif.mdu_op = 3'd0;
        @(negedge clk); mif.start = 1'b1; mif.mdu_op = 3'd3; mif.A = 100; mif.B = 3;
        @(negedge clk); mif.start = 1'b0; mif.mdu_op = 3'd5; mif.A = 32'hDEAD;
        @(negedge clk); mif.mdu_op = 3'd0;
        n = 3;
        while (mif.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("guard_len", n, 5);
        check_hl("guard", 32'h0, 32'd35);

        @(negedge clk); mif.start = 1'b1; mif.mdu_op = 3'd3; mif.A = 100; mif.B = 7;
        @(negedge clk); mif.start = 1'b0; mif.mdu_op = 3'd0;
        repeat (2) @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rstmid_busy", {31'd0, mif.busy}, 32'd0);
        check_hl("rstmid", 32'h0, 32'h0);
        repeat (12) @(negedge clk);
        check_hl("rstlate", 32'h0, 32'h0);
        launch(3'd1, 32'd6, 32'd7, n);
        check("post_len", n, 5);
        check_hl("post", 32'h0, 32'd42);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 99) == 0);
            mif.start  = ($urandom_range(0, 1) == 1);
            mif.mdu_op = 3'($urandom_range(0, 7));
            mif.A      = pick();
            mif.B      = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
        end
        @(negedge clk);
        reset = 1'b0; mif.start = 1'b0; mif.mdu_op = 3'd0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
